// File: rtl/salamander_pkg.sv
// ============================================================================
// Module      : salamander_pkg
// Description : Shared widths and fetch state encoding for the fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package salamander_pkg;

    localparam int c_ADDR_W  = 5;
    localparam int c_INSTR_W = 6;
    localparam int c_DEPTH   = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FLUSH  = 2'd2
    } fetch_state_t;

    // Pointer width that stays legal for a single-entry buffer.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Small prefetch buffer with push, pop, flush and occupancy out.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
    import salamander_pkg::*;
#(
    parameter int DEPTH = c_DEPTH,
    parameter int WIDTH = c_INSTR_W + c_ADDR_W,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = ptr_w(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    // Pointers wrap at DEPTH so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = pop & ~w_empty;
    assign w_do_push = push & (~w_full | w_do_pop);

    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (rst) begin
                r_mem[i] <= '0;
            end else if (w_do_push && (r_wr_ptr == PTR_W'(i))) begin
                r_mem[i] <= push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Prefetching instruction fetch with redirect, halt and buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import salamander_pkg::*;
#(
    parameter int ADDR_W  = c_ADDR_W,
    parameter int INSTR_W = c_INSTR_W,
    parameter int DEPTH   = c_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_rd_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               dec_valid,
    input  logic               dec_ready,
    output logic [INSTR_W-1:0] dec_instr,
    output logic [ADDR_W-1:0]  dec_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    input  logic               halt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OCC_W = CNT_W + 1;
    localparam int ENT_W = INSTR_W + ADDR_W;

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rd_pc;
    logic              r_inflight;

    logic [CNT_W-1:0]  w_count;
    logic [OCC_W-1:0]  w_occ_next;
    logic [ENT_W-1:0]  w_head;
    logic              w_pop;
    logic              w_push;
    logic              w_rd_en;
    logic              w_fetch_state;

    always_comb begin
        w_state_next = r_state;
        if (redirect_valid) begin
            w_state_next = FLUSH;
        end else begin
            case (r_state)
                RUN:     w_state_next = halt ? HALTED : RUN;
                HALTED:  w_state_next = halt ? HALTED : RUN;
                FLUSH:   w_state_next = halt ? HALTED : RUN;
                default: w_state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign dec_valid = (w_count != '0) & ~rst;
    assign w_pop     = dec_valid & dec_ready;

    // Occupancy the buffer will reach once the outstanding read lands.
    assign w_occ_next = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);

    // FLUSH also fetches so the redirect target is read in the cycle after it.
    assign w_fetch_state = (r_state == RUN) || (r_state == FLUSH);
    assign w_rd_en = ~rst & ~halt & ~redirect_valid & w_fetch_state
                   & (w_occ_next < OCC_W'(DEPTH));

    assign imem_rd_en = w_rd_en;
    assign imem_addr  = r_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc       <= '0;
            r_rd_pc    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if (w_rd_en) begin
                r_rd_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc <= redirect_addr;
            end else if (w_rd_en) begin
                r_pc <= r_pc + ADDR_W'(1);
            end
        end
    end

    // A redirect squashes the response arriving on the same edge.
    assign w_push = r_inflight & ~redirect_valid;

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({imem_rdata, r_rd_pc}),
        .pop       (w_pop & ~redirect_valid),
        .flush     (redirect_valid),
        .head_data (w_head),
        .count     (w_count)
    );

    assign dec_instr = w_head[ENT_W-1 -: INSTR_W];
    assign dec_pc    = w_head[ADDR_W-1:0];

endmodule

`default_nettype wire
